multi_cycle_ctrl: RTL
=====================

// Module: multi_cycle_ctrl
// PURPOSE
//  Main control FSM for the multi-cycle RV32I-subset CPU (add/sub/and/or/xor, addi-class I-ALU, ld, sd, beq/bne/blt/bge).
//  Sequences one shared datapath through FETCH/DECODE/EXEC/MEM/WB.
//  Handshakes with variable-latency imem/dmem via ready inputs.
//  Emits per-state datapath strobes, a retired-instruction counter and a sticky illegal-instruction halt.
// PARAMETERS
//  RETIRE_CNT_WIDTH  32  width of retired_cnt; wraps modulo 2^RETIRE_CNT_WIDTH
// PORTS
//  clk          in   1   system clock
//  reset_b      in   1   reset, asynchronous, active-low
//  opcode       in   7   IR[6:0]; valid from DECODE until next FETCH completes
//  funct3       in   3   IR[14:12]
//  alu_zero     in   1   ALU result == 0
//  alu_sign     in   1   ALU result[31]
//  imem_ready   in   1   imem read data valid this cycle
//  dmem_ready   in   1   dmem access completes this cycle
//  imem_req     out  1   instruction fetch request
//  ir_write     out  1   latch imem dout into IR
//  mdr_write    out  1   latch dmem dout into MDR
//  pc_write     out  1   update PC at this clock edge
//  pc_src       out  1   0: PC+4, 1: PC+(imm<<1)
//  alu_src      out  1   0: rs2, 1: imm32
//  alu_op       out  2   00 add (ld/sd), 01 sub (branch), 10 funct-decoded (R/I)
//  mem_read     out  1   dmem read request
//  mem_write    out  1   dmem write request
//  mem_to_reg   out  1   rd_din select: 1 = MDR
//  reg_write    out  1   regfile write enable
//  illegal      out  1   sticky: unsupported opcode/funct3 decoded
//  state        out  3   FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=5
//  retired_cnt  out  W   instructions retired since reset
// BEHAVIOUR
//  Reset (async): state=FETCH, retired_cnt=0, illegal=0.
//  - Strobes are combinational from state; imem_req=1 while in FETCH, including during reset.
//  - All other strobes are 0 during reset.
//  - Reset mid-operation drops any outstanding request immediately; no access is completed.
//  FETCH: imem_req=1, held until imem_ready.
//  - Cycle with imem_ready=1: ir_write=1, next=DECODE.
//  DECODE: legal classes are R (0110011), I-ALU (0010011), ld (0000011), sd (0100011), branch (1100011).
//  - Branch legal only for funct3 in {000,001,100,101}.
//  - Legal -> EXEC; else -> HALT and set illegal.
//  EXEC: alu_op per class; alu_src=1 for I-ALU/ld/sd.
//  - R/I -> WB; ld/sd -> MEM.
//  - branch: pc_write=1, pc_src=taken, retire, -> FETCH.
//  - taken: beq=zero, bne=~zero, blt=sign, bge=~sign.
//  MEM: alu_src=1, alu_op=00; mem_read (ld) or mem_write (sd) held stable until dmem_ready.
//  - ld on ready: mdr_write=1, -> WB.
//  - sd on ready: pc_write=1, pc_src=0, retire, -> FETCH.
//  WB: reg_write=1, mem_to_reg=(ld), pc_write=1, pc_src=0, retire, -> FETCH.
//  HALT: terminal until reset; all strobes 0, illegal=1, retired_cnt frozen.
//  - Ready inputs are ignored in every state except FETCH/MEM.
//  - imem_req and mem_read/mem_write are never asserted simultaneously.
//  Retire: retired_cnt increments by 1 at the edge ending the retiring cycle; wraps to 0.
//  Latency at zero wait states: branch 3, R/I/sd 4, ld 5 cycles.
//  - Each wait cycle adds 1 to the state it stalls.
// TESTING
//  Test 1 (R-type add, readys=1):
//  - States 0,1,2,4,0.
//  - reg_write and pc_write high only in the WB cycle, alu_op=10.
//  - retired_cnt 0->1 after 4 cycles.
//  Test 2 (ld, dmem_ready low 3 cycles):
//  - MEM lasts 4 cycles with mem_read=1.
//  - mdr_write only in the ready cycle, then WB with mem_to_reg=1.
//  - 8 cycles total.
//  Test 3 (bne):
//  - alu_zero=0 -> EXEC pc_write=1, pc_src=1; alu_zero=1 -> pc_src=0.
//  - Repeat for blt/bge with alu_sign=1/0.
//  - 3 cycles each.
//  Test 4 (opcode 7'h7F or branch funct3=010):
//  - DECODE->HALT, illegal=1 sticky.
//  - imem_req=0 thereafter, retired_cnt unchanged for 20 cycles.
//  Test 5 (sd, reset_b low while in MEM):
//  - mem_write drops the same cycle, state=FETCH, retired_cnt=0.
//  - Normal fetch resumes after release.
//  Test 6 (RETIRE_CNT_WIDTH=4, 17 branches):
//  - retired_cnt wraps 15->0->1.
//  - imem_ready toggled randomly: ir_write only when imem_ready=1.

Source files
------------

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM for a multi-cycle RV32I-subset CPU.
// Sequences the shared datapath through FETCH/DECODE/EXEC/MEM/WB.
// It waits on imem_ready and dmem_ready for variable-latency memories.
// It also keeps a count of retired instructions and a sticky illegal-instruction halt.
module multi_cycle_ctrl #(
    parameter int RETIRE_CNT_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        reset_b,
    input  logic [6:0]                  opcode,
    input  logic [2:0]                  funct3,
    input  logic                        alu_zero,
    input  logic                        alu_sign,
    input  logic                        imem_ready,
    input  logic                        dmem_ready,
    output logic                        imem_req,
    output logic                        ir_write,
    output logic                        mdr_write,
    output logic                        pc_write,
    output logic                        pc_src,
    output logic                        alu_src,
    output logic [1:0]                  alu_op,
    output logic                        mem_read,
    output logic                        mem_write,
    output logic                        mem_to_reg,
    output logic                        reg_write,
    output logic                        illegal,
    output logic [2:0]                  state,
    output logic [RETIRE_CNT_WIDTH-1:0] retired_cnt
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    localparam logic [RETIRE_CNT_WIDTH-1:0] CNT_ONE =
        {{(RETIRE_CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                      state_q, state_d;
    logic                        illegal_q, illegal_d;
    logic [RETIRE_CNT_WIDTH-1:0] retired_cnt_q, retired_cnt_d;

    logic is_r, is_i, is_ld, is_sd, is_br;
    logic br_funct_ok, legal, br_taken, retire;

    // Instruction class decode; IR is stable from DECODE until the next fetch completes
    always_comb begin
        is_r        = (opcode == OP_R);
        is_i        = (opcode == OP_I);
        is_ld       = (opcode == OP_LD);
        is_sd       = (opcode == OP_SD);
        is_br       = (opcode == OP_BR);
        br_funct_ok = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                      (funct3 == 3'b100) || (funct3 == 3'b101);
        legal       = is_r || is_i || is_ld || is_sd || (is_br && br_funct_ok);
        case (funct3)
            3'b000:  br_taken = alu_zero;
            3'b001:  br_taken = ~alu_zero;
            3'b100:  br_taken = alu_sign;
            3'b101:  br_taken = ~alu_sign;
            default: br_taken = 1'b0;
        endcase
    end

    // State, sticky illegal flag and retire counter registers
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q       <= FETCH;
            illegal_q     <= 1'b0;
            retired_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            illegal_q     <= illegal_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    // Next-state logic and per-state datapath strobes
    always_comb begin
        state_d    = state_q;
        illegal_d  = illegal_q;
        retire     = 1'b0;
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        mdr_write  = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 2'b00;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;

        unique case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                if (legal) begin
                    state_d = EXEC;
                end else begin
                    state_d   = HALT;
                    illegal_d = 1'b1;
                end
            end
            EXEC: begin
                if (is_r) begin
                    alu_op  = 2'b10;
                    state_d = WB;
                end else if (is_i) begin
                    alu_src = 1'b1;
                    alu_op  = 2'b10;
                    state_d = WB;
                end else if (is_ld || is_sd) begin
                    alu_src = 1'b1;
                    state_d = MEM;
                end else begin
                    alu_op   = 2'b01;
                    pc_write = 1'b1;
                    pc_src   = br_taken;
                    retire   = 1'b1;
                    state_d  = FETCH;
                end
            end
            MEM: begin
                alu_src = 1'b1;
                if (is_ld) begin
                    mem_read = 1'b1;
                    if (dmem_ready) begin
                        mdr_write = 1'b1;
                        state_d   = WB;
                    end
                end else begin
                    mem_write = 1'b1;
                    if (dmem_ready) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_d  = FETCH;
                    end
                end
            end
            WB: begin
                reg_write  = 1'b1;
                mem_to_reg = is_ld;
                pc_write   = 1'b1;
                retire     = 1'b1;
                state_d    = FETCH;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        // While reset is held only the fetch request may be visible
        if (!reset_b) begin
            ir_write = 1'b0;
        end

        retired_cnt_d = retire ? (retired_cnt_q + CNT_ONE) : retired_cnt_q;
    end

    assign state       = state_q;
    assign illegal     = illegal_q;
    assign retired_cnt = retired_cnt_q;

endmodule
